// File: rtl/mem_access_unit.sv
// mem_access_unit
//   CPU-side initiator for the OTTER single-port, byte-enabled data memory.
//   It accepts one load/store request from the multicycle control unit and
//   turns it into one or two word-aligned memory transactions. On those
//   transactions it drives per-lane write enables and lane-shifted store data.
//   For loads it merges the returned words and sign/zero-extends the result.
//   It finishes with a one-cycle done pulse, plus error for illegal sizes or
//   out-of-range addresses.
//
//   Handshake: a request is taken only when busy=0 (state IDLE) and
//   req_valid=1 on a rising edge. All req_* fields are latched on that edge.
//   A req_valid seen in any other state (including the DONE/ERR cycle) is
//   dropped: it is not queued and it raises no error. Completion is the
//   single-cycle done pulse. rdata and error are meaningful only while
//   done=1.
//
//   Memory side: mem_rdata is a synchronous read. A word addressed in PH1/PH2
//   returns on the following cycle (CAP1/CAP2), where it is captured.
//   state_dbg exposes the FSM state so external checkers can follow the
//   sequencing.
//
//   BUS_WIDTH is fixed at 32; the lane arithmetic below assumes four byte
//   lanes.

module mem_access_unit #(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [BUS_WIDTH-1:0]  req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  busy,
    output logic                  done,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic [2:0]            state_dbg
);

    // FSM encoding; IDLE is zero so a reset register file reads as idle.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PH1  = 3'd1;
    localparam logic [2:0] CAP1 = 3'd2;
    localparam logic [2:0] PH2  = 3'd3;
    localparam logic [2:0] CAP2 = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    // Access size codes as seen on req_size.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // Distance between the two words of a split access.
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    logic [2:0]            state;
    logic [2:0]            state_next;

    // Request fields latched at acceptance; the live req_* bus is ignored
    // afterwards.
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0]  r_wdata;
    logic [1:0]            r_size;
    logic                  r_sign;

    // Captured read words: rd1 from word 1, rd2 from word 2 (zero if unsplit).
    logic [BUS_WIDTH-1:0]  rd1;
    logic [BUS_WIDTH-1:0]  rd2;

    logic                  accept;
    logic                  req_bad;
    logic [1:0]            off;
    logic                  split;
    logic [ADDR_WIDTH-1:0] word1;
    logic [ADDR_WIDTH-1:0] word2;
    logic [4:0]            lane_shift;
    logic [3:0]            base_mask;
    logic [7:0]            mask8;
    logic [2*BUS_WIDTH-1:0] wdata_wide;
    logic [BUS_WIDTH-1:0]  merged;
    logic [BUS_WIDTH-1:0]  load_ext;

    // Acceptance and legality of the request currently presented in IDLE.
    always_comb begin
        accept  = (state == IDLE) && req_valid;
        req_bad = (req_size == SIZE_BAD) || (|req_addr[BUS_WIDTH-1:ADDR_WIDTH]);
    end

    // Access geometry derived from the latched request: offset, split
    // decision, the two word addresses (word 2 wraps at the top of memory)
    // and the byte-lane shift amount.
    always_comb begin
        off        = r_addr[1:0];
        split      = ((r_size == SIZE_HALF) && (off == 2'b11)) ||
                     ((r_size == SIZE_WORD) && (off != 2'b00));
        word1      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        word2      = word1 + WORD_STEP;
        lane_shift = {off, 3'b000};
    end

    // Store side: an 8-lane enable mask and a 64-bit data vector spanning both
    // words. The low half serves PH1 and the high half serves PH2.
    always_comb begin
        case (r_size)
            SIZE_BYTE: base_mask = 4'b0001;
            SIZE_HALF: base_mask = 4'b0011;
            SIZE_WORD: base_mask = 4'b1111;
            default:   base_mask = 4'b0000;
        endcase
        mask8      = {4'b0000, base_mask} << off;
        wdata_wide = {{BUS_WIDTH{1'b0}}, r_wdata} << lane_shift;
    end

    // Load side: shift the {rd2, rd1} pair down by the byte offset, keep the
    // requested width and extend. req_sign=0 means signed; word loads pass
    // through untouched.
    always_comb begin
        merged = BUS_WIDTH'({rd2, rd1} >> lane_shift);
        case (r_size)
            SIZE_BYTE: load_ext = {{(BUS_WIDTH-8){merged[7] & ~r_sign}}, merged[7:0]};
            SIZE_HALF: load_ext = {{(BUS_WIDTH-16){merged[15] & ~r_sign}}, merged[15:0]};
            default:   load_ext = merged;
        endcase
    end

    // Next-state sequencing: PH1 -> (CAP1) -> (PH2 -> (CAP2)) -> DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? ERR : PH1;
                end
            end
            PH1: begin
                if (!r_we) begin
                    state_next = CAP1;
                end else if (split) begin
                    state_next = PH2;
                end else begin
                    state_next = DONE;
                end
            end
            CAP1:    state_next = split ? PH2 : DONE;
            PH2:     state_next = r_we ? DONE : CAP2;
            CAP2:    state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request fields on acceptance; they stay frozen until the
    // next accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= SIZE_BYTE;
            r_sign  <= 1'b0;
        end else if (accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr[ADDR_WIDTH-1:0];
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_sign  <= req_sign;
        end
    end

    // Capture read data one cycle after each word address was presented.
    // rd2 is cleared on acceptance so unsplit loads merge against zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (accept) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (state == CAP1) begin
            rd1 <= mem_rdata;
        end else if (state == CAP2) begin
            rd2 <= mem_rdata;
        end
    end

    // Memory-side drive. The word address is held through each capture
    // cycle. Write enables and data are asserted only in the drive phases of
    // a store.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 4'b0000;
        mem_wdata = '0;
        case (state)
            PH1: begin
                mem_addr = word1;
                if (r_we) begin
                    mem_we    = mask8[3:0];
                    mem_wdata = wdata_wide[BUS_WIDTH-1:0];
                end
            end
            CAP1: mem_addr = word1;
            PH2: begin
                mem_addr = word2;
                if (r_we) begin
                    mem_we    = mask8[7:4];
                    mem_wdata = wdata_wide[2*BUS_WIDTH-1:BUS_WIDTH];
                end
            end
            CAP2: mem_addr = word2;
            default: begin
                mem_addr  = '0;
                mem_we    = 4'b0000;
                mem_wdata = '0;
            end
        endcase
    end

    // Control-unit status. rdata carries the load result only in DONE and
    // reads zero otherwise, including in ERR.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE) || (state == ERR);
        error     = (state == ERR);
        rdata     = ((state == DONE) && !r_we) ? load_ext : '0;
        state_dbg = state;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Bench for mem_access_unit. It models the data memory as a synchronous-read
//   word array driven by the DUT. A byte-level reference memory tracks every
//   store, and expected load data, error, latency and write activity are
//   computed from the access rules.

module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        error;
    logic [12:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  state_dbg;

    mem_access_unit #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .error     (error),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- memory model (DUT side) ----------------
    logic [31:0] mem [0:2047];
    logic        mem_clear;
    logic        poke_en;
    logic [12:0] poke_addr;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
        end else if (poke_en) begin
            mem[poke_addr[12:2]] <= poke_data;
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_we[k]) mem[mem_addr[12:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
        mem_rdata <= mem[mem_addr[12:2]];
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] ref_mem [0:8191];
    int tests;
    int fails;
    int accepted;
    int done_cnt;

    always @(negedge clk) begin
        if (!rst && done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    task automatic model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic sign, output logic [31:0] rd, output logic err,
                         output int lat, output int nwe);
        int n;
        int base;
        bit split;
        n     = size_bytes(size);
        base  = int'(addr[12:0]);
        err   = (size == 2'b11) || (addr >= 32'h2000);
        split = ((base % 4) + n) > 4;
        rd    = 32'h0;
        if (err) begin
            lat = 1;
            nwe = 0;
        end else if (we) begin
            lat = split ? 3 : 2;
            nwe = split ? 2 : 1;
        end else begin
            lat = split ? 5 : 3;
            nwe = 0;
            for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[(base + i) % 8192];
            if (!sign && n == 1 && rd[7])  rd[31:8]  = '1;
            if (!sign && n == 2 && rd[15]) rd[31:16] = '1;
        end
    endtask

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int base;
        n    = size_bytes(size);
        base = int'(addr[12:0]);
        for (int i = 0; i < n; i++) ref_mem[(base + i) % 8192] = wdata[8*i +: 8];
    endtask

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [12:0] a, input logic [31:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[int'({a[12:2], 2'b00}) + i] = d[8*i +: 8];
    endtask

    // Present a request for one cycle; returns at the negedge of cycle 1.
    task automatic start_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic sign);
        @(posedge clk);
        #1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_sign  = sign;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Full transaction with noise on req_* while busy (must be ignored).
    task automatic run_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic sign,
                           output int lat, output logic [31:0] rd, output logic err, output int nwe);
        bit got;
        start_req(we, size, addr, wdata, sign);
        lat = 99;
        rd  = 32'h0;
        err = 1'bx;
        nwe = 0;
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_we != 4'b0000) nwe++;
            if (done) begin
                lat = c;
                rd  = rdata;
                err = error;
                got = 1;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 3));
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_sign  = 1'($urandom_range(0, 1));
            if (got) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        accepted++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sign;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwe;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [0:NV-1];

    initial begin
        int lat;
        int nwe;
        int cnt;
        logic [31:0] rd;
        logic err;
        logic        m_err;
        logic [31:0] m_rd;
        int          m_lat;
        int          m_nwe;
        logic        r_we;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic        r_sign;
        int          sel;

        tests = 0; fails = 0; accepted = 0; done_cnt = 0;
        rst = 1'b1; mem_clear = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_sign = 1'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_rdata", rdata,      32'h0);
        check("rst_we",    32'(mem_we), 32'h0);
        check("rst_addr",  32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata,  32'h0);
        rst = 1'b0;
        mem_clear = 1'b0;

        // Aligned word store, cycle by cycle.
        start_req(1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 1'b0);
        check("sw_ph1_addr",  32'(mem_addr), 32'h20);
        check("sw_ph1_we",    32'(mem_we),   32'hF);
        check("sw_ph1_wdata", mem_wdata,     32'hDEADBEEF);
        @(negedge clk);
        check("sw_done",    32'(done),   32'h1);
        check("sw_err",     32'(error),  32'h0);
        check("sw_done_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        check("sw_idle_busy", 32'(busy), 32'h0);
        check("sw_idle_done", 32'(done), 32'h0);
        ref_store(2'b10, 32'h20, 32'hDEADBEEF);
        accepted++;

        // Split half store at 0x103, cycle by cycle.
        start_req(1'b1, 2'b01, 32'h103, 32'h0000BEEF, 1'b0);
        check("sh_ph1_addr",  32'(mem_addr), 32'h100);
        check("sh_ph1_we",    32'(mem_we),   32'h8);
        check("sh_ph1_wdata", mem_wdata,     32'hEF000000);
        @(negedge clk);
        check("sh_ph2_addr",  32'(mem_addr), 32'h104);
        check("sh_ph2_we",    32'(mem_we),   32'h1);
        check("sh_ph2_wdata", mem_wdata,     32'h000000BE);
        check("sh_ph2_done",  32'(done),     32'h0);
        @(negedge clk);
        check("sh_done",    32'(done),   32'h1);
        check("sh_done_we", 32'(mem_we), 32'h0);
        ref_store(2'b01, 32'h103, 32'h0000BEEF);
        accepted++;

        // Memory image for the table.
        poke(13'h000,  32'h12345678);
        poke(13'h100,  32'h8899AABB);
        poke(13'h104,  32'h00000000);
        poke(13'h300,  32'h44332211);
        poke(13'h304,  32'h88776655);
        poke(13'h1FFC, 32'hCAFEF00D);

        vecs[0]  = '{1'b0, 2'b00, 32'h103,      32'h0,        1'b0, 1'b1, 32'hFFFFFF88, 1'b0, 3, 0};
        vecs[1]  = '{1'b0, 2'b00, 32'h103,      32'h0,        1'b1, 1'b1, 32'h00000088, 1'b0, 3, 0};
        vecs[2]  = '{1'b0, 2'b00, 32'h101,      32'h0,        1'b0, 1'b1, 32'hFFFFFFAA, 1'b0, 3, 0};
        vecs[3]  = '{1'b0, 2'b01, 32'h102,      32'h0,        1'b0, 1'b1, 32'hFFFF8899, 1'b0, 3, 0};
        vecs[4]  = '{1'b0, 2'b01, 32'h100,      32'h0,        1'b1, 1'b1, 32'h0000AABB, 1'b0, 3, 0};
        vecs[5]  = '{1'b0, 2'b10, 32'h100,      32'h0,        1'b0, 1'b1, 32'h8899AABB, 1'b0, 3, 0};
        vecs[6]  = '{1'b0, 2'b10, 32'h302,      32'h0,        1'b0, 1'b1, 32'h66554433, 1'b0, 5, 0};
        vecs[7]  = '{1'b0, 2'b01, 32'h303,      32'h0,        1'b0, 1'b1, 32'h00005544, 1'b0, 5, 0};
        vecs[8]  = '{1'b0, 2'b10, 32'h1FFF,     32'h0,        1'b0, 1'b1, 32'h345678CA, 1'b0, 5, 0};
        vecs[9]  = '{1'b0, 2'b11, 32'h10,       32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1, 1, 0};
        vecs[10] = '{1'b1, 2'b10, 32'h2000,     32'hA5A5A5A5, 1'b0, 1'b1, 32'h00000000, 1'b1, 1, 0};
        vecs[11] = '{1'b0, 2'b00, 32'hFFFF0000, 32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1, 1, 0};
        vecs[12] = '{1'b1, 2'b11, 32'h10,       32'h11111111, 1'b0, 1'b1, 32'h00000000, 1'b1, 1, 0};
        vecs[13] = '{1'b0, 2'b10, 32'h20,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 0};
        vecs[14] = '{1'b1, 2'b10, 32'h24,       32'h0BADF00D, 1'b0, 1'b0, 32'h0,        1'b0, 2, 1};
        vecs[15] = '{1'b0, 2'b10, 32'h24,       32'h0,        1'b1, 1'b1, 32'h0BADF00D, 1'b0, 3, 0};
        vecs[16] = '{1'b1, 2'b01, 32'h103,      32'h0000BEEF, 1'b0, 1'b0, 32'h0,        1'b0, 3, 2};
        vecs[17] = '{1'b0, 2'b01, 32'h103,      32'h0,        1'b1, 1'b1, 32'h0000BEEF, 1'b0, 5, 0};
        vecs[18] = '{1'b0, 2'b10, 32'h100,      32'h0,        1'b0, 1'b1, 32'hEF99AABB, 1'b0, 3, 0};
        vecs[19] = '{1'b1, 2'b00, 32'h2,        32'h0000005A, 1'b0, 1'b0, 32'h0,        1'b0, 2, 1};
        vecs[20] = '{1'b0, 2'b10, 32'h0,        32'h0,        1'b0, 1'b1, 32'h125A5678, 1'b0, 3, 0};
        vecs[21] = '{1'b0, 2'b01, 32'h1FFE,     32'h0,        1'b0, 1'b1, 32'hFFFFCAFE, 1'b0, 3, 0};
        vecs[22] = '{1'b1, 2'b01, 32'h1FFF,     32'h00001234, 1'b0, 1'b0, 32'h0,        1'b0, 3, 2};
        vecs[23] = '{1'b0, 2'b10, 32'h0,        32'h0,        1'b0, 1'b1, 32'h125A5612, 1'b0, 3, 0};
        vecs[24] = '{1'b0, 2'b10, 32'h1FFC,     32'h0,        1'b0, 1'b1, 32'h34FEF00D, 1'b0, 3, 0};

        for (int v = 0; v < NV; v++) begin
            run_req(vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata, vecs[v].sign,
                    lat, rd, err, nwe);
            check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_nwe", v), 32'(nwe), 32'(vecs[v].exp_nwe));
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            if (vecs[v].we && !vecs[v].exp_err) ref_store(vecs[v].size, vecs[v].addr, vecs[v].wdata);
        end

        // Word load at the top word: second read wraps to address 0.
        model(1'b0, 2'b10, 32'h1FFF, 1'b0, m_rd, m_err, m_lat, m_nwe);
        start_req(1'b0, 2'b10, 32'h1FFF, 32'h0, 1'b0);
        check("wrap_ph1_addr", 32'(mem_addr), 32'h1FFC);
        @(negedge clk);
        @(negedge clk);
        check("wrap_ph2_addr", 32'(mem_addr), 32'h0000);
        check("wrap_ph2_busy", 32'(busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("wrap_done",  32'(done), 32'h1);
        check("wrap_rdata", rdata, m_rd);
        accepted++;

        // Reset during PH2 of a split load.
        start_req(1'b0, 2'b10, 32'h302, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_ph2_addr", 32'(mem_addr), 32'h304);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy",  32'(busy),      32'h0);
        check("rstmid_done",  32'(done),      32'h0);
        check("rstmid_we",    32'(mem_we),    32'h0);
        check("rstmid_state", 32'(state_dbg), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_after_done", 32'(done), 32'h0);

        // Requests pulsed while busy are dropped: no trailing done pulses.
        run_req(1'b0, 2'b10, 32'h302, 32'h0, 1'b0, lat, rd, err, nwe);
        check("busy_rdata", rd, 32'h66554433);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("busy_no_extra_done", 32'(cnt), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            sel     = $urandom_range(0, 9);
            r_size  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            r_wdata = $urandom;
            r_sign  = 1'($urandom_range(0, 1));
            sel     = $urandom_range(0, 9);
            if (sel == 0) begin
                r_addr = $urandom;
                r_addr[13] = 1'b1;
            end else if (sel < 3) begin
                r_addr = 32'h1FFC + 32'($urandom_range(0, 3));
            end else begin
                r_addr = 32'($urandom_range(0, 63));
            end
            model(r_we, r_size, r_addr, r_sign, m_rd, m_err, m_lat, m_nwe);
            run_req(r_we, r_size, r_addr, r_wdata, r_sign, lat, rd, err, nwe);
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(m_err));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_nwe", i), 32'(nwe), 32'(m_nwe));
            if (!r_we || m_err) check($sformatf("rnd%0d_rdata", i), rd, m_rd);
            if (r_we && !m_err) ref_store(r_size, r_addr, r_wdata);
        end

        // Final memory image and completion accounting.
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int w = 0; w < 2048; w++)
            for (int b = 0; b < 4; b++)
                if (mem[w][8*b +: 8] !== ref_mem[4*w + b]) cnt++;
        check("mem_final_bytes", 32'(cnt), 32'h0);
        check("done_pulse_count", 32'(done_cnt), 32'(accepted));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the OTTER single-port byte-enabled data memory.
- Takes one load/store request from the multicycle control unit.
- Converts it into one or two word-aligned memory transactions:
  - generates per-lane write enables;
  - lane-shifts write data;
  - merges and sign/zero-extends read data.
- Reports completion or an access error back to the control unit.

Parameters:
- ADDR_WIDTH, 13, width of the memory-side byte address; memory spans 2^ADDR_WIDTH bytes.
- BUS_WIDTH, 32, CPU data/address bus width. Only 32 is supported.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe; sampled only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  BUS_WIDTH  byte address.
- req_wdata  input  BUS_WIDTH  store data, right-justified.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_sign  input  1  0 = signed load, 1 = unsigned load.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  BUS_WIDTH  extended load result; valid while done=1.
- error  output  1  valid while done=1; high means illegal size or out-of-range address.
- mem_addr  output  ADDR_WIDTH  word-aligned address to memory; bits [1:0] are always 00.
- mem_we  output  4  per-byte write enable, lane 0 = bits [7:0].
- mem_wdata  output  BUS_WIDTH  lane-aligned store data.
- mem_rdata  input  BUS_WIDTH  memory read data; synchronous read, valid the cycle after mem_addr is driven.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, error=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: state returns to IDLE and mem_we is 0 from the next cycle on. Any half-written split store is not rolled back.
- States and transitions:
  - IDLE → PH1 when req_valid=1. All req_* inputs are latched in this cycle; later changes to req_* have no effect.
  - IDLE → ERR instead when req_size=11 or req_addr[BUS_WIDTH-1:ADDR_WIDTH] is nonzero.
  - PH1: drive word 1 address and the low half of the lane/enable vectors.
    - load → CAP1;
    - split store → PH2;
    - otherwise → DONE.
  - CAP1: capture mem_rdata as rd1. Split load → PH2, otherwise → DONE.
  - PH2: drive word 2 address and the high half of the lane/enable vectors. Load → CAP2, store → DONE.
  - CAP2: capture mem_rdata as rd2, then → DONE.
  - DONE: done=1 and error=0 for one cycle, then → IDLE.
  - ERR: done=1, error=1, rdata=0 for one cycle, then → IDLE. No memory write is performed.
- mem_we is nonzero only in PH1/PH2 of a store. In all other states it is 0.
- Offset and split rule:
  - off = addr[1:0].
  - Split when (size=01 and off=11) or (size=10 and off≠00). Bytes never split.
- Word addresses:
  - Word 1 = {addr[ADDR_WIDTH-1:2],00}.
  - Word 2 = word 1 + 4, modulo 2^ADDR_WIDTH, so the top word wraps to 0.
- Write enables: 8-bit mask = (0001 / 0011 / 1111 by size) << off. Bits [3:0] drive PH1; bits [7:4] drive PH2.
- Write data: 64-bit vector = {32'b0, wdata} << (8*off). Low word drives PH1; high word drives PH2.
- Load merge:
  - m = {rd2, rd1} >> (8*off), with rd2=0 when the access is not split.
  - Take the low 8/16/32 bits by size.
  - Sign-extend when sign=0; zero-extend when sign=1.
  - A word load ignores sign.
- Latency, counted from the req_valid cycle to the done cycle:
  - aligned store: 2;
  - split store: 3;
  - aligned load: 3;
  - split load: 5;
  - error: 1.
- req_valid while busy=1 is ignored; it is neither queued nor errored.
- req_valid in the DONE or ERR cycle is ignored. The next request is accepted in IDLE.

Test Plan:
- Signed byte load: mem[0x100]=0x8899AABB; load byte signed @0x103 → done at cycle 3, rdata=0xFFFFFF88. Unsigned → 0x00000088.
- Aligned word store: store word 0xDEADBEEF @0x20 → PH1 mem_addr=0x20, mem_we=1111, mem_wdata=0xDEADBEEF; done at cycle 2; no second access.
- Split half store: store half 0x0000BEEF @0x103 → PH1 addr 0x100, we=1000, wdata=0xEF000000; PH2 addr 0x104, we=0001, wdata=0x000000BE; done at cycle 3.
- Split word load: mem[0x100]=0x44332211, mem[0x104]=0x88776655; load word @0x102 → rdata=0x66554433, done at cycle 5. Load word @0x1FFF (ADDR_WIDTH=13) → second read at mem_addr 0x0000.
- Errors, no writes issued:
  - size=11 @0x10 → done=1, error=1 at cycle 1, mem_we=0 throughout.
  - store @0x00002000 → same response.
- Reset and busy handling:
  - Assert rst during PH2 of a split load → next cycle state IDLE, busy=0, done=0, mem_we=0.
  - req_valid pulsed while busy → ignored; exactly one done pulse per accepted request.
